// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port among cache-side requesters.
// Tracks outstanding reads/writes per memory serial and routes completions back to their owner.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned SERIAL_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_PORTS-1:0]          reqValid,
    input  logic [NUM_PORTS-1:0]          reqWE,
    input  logic [NUM_PORTS*ADDR_W-1:0]   reqAddr,
    input  logic [NUM_PORTS*DATA_W-1:0]   reqWData,
    output logic [NUM_PORTS-1:0]          reqAck,
    output logic [SERIAL_W-1:0]           reqSerial,

    output logic [ADDR_W-1:0]             memAccessAddr,
    output logic [DATA_W-1:0]             memAccessWriteData,
    output logic                          memAccessRE,
    output logic                          memAccessWE,
    input  logic                          memAccessReadBusy,
    input  logic                          memAccessWriteBusy,
    input  logic [SERIAL_W-1:0]           nextMemReadSerial,
    input  logic [SERIAL_W-1:0]           nextMemWriteSerial,

    input  logic                          memReadDataReady,
    input  logic [DATA_W-1:0]             memReadData,
    input  logic [SERIAL_W-1:0]           memReadSerial,
    input  logic                          memWriteDoneValid,
    input  logic [SERIAL_W-1:0]           memWriteDoneSerial,

    output logic [NUM_PORTS-1:0]          rspValid,
    output logic [DATA_W-1:0]             rspData,
    output logic [SERIAL_W-1:0]           rspSerial,
    output logic [NUM_PORTS-1:0]          wrDone,
    output logic [SERIAL_W:0]             outstandingReads,
    output logic                          errUnexpected
);

    localparam int unsigned DEPTH = 1 << SERIAL_W;
    localparam int unsigned OWN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = SERIAL_W + 1;

    // Serial-indexed ownership tables; owners are only meaningful while valid.
    logic [DEPTH-1:0] rd_valid;
    logic [DEPTH-1:0] wr_valid;
    logic [OWN_W-1:0] rd_owner [DEPTH];
    logic [OWN_W-1:0] wr_owner [DEPTH];

    logic [OWN_W-1:0] rr_ptr;
    logic [CNT_W-1:0] rd_count;

    logic                 rd_open;
    logic                 wr_open;
    logic [NUM_PORTS-1:0] eligible;
    logic                 grant_any;
    logic [OWN_W-1:0]     grant_idx;
    logic                 grant_we;
    logic                 rd_alloc;
    logic                 wr_alloc;
    logic                 rd_free;
    logic                 wr_free;
    logic                 rd_unexpected;
    logic                 wr_unexpected;

    function automatic logic [OWN_W-1:0] wrap_add(input logic [OWN_W-1:0] base,
                                                  input int unsigned     offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return OWN_W'(sum);
    endfunction

    // A port can go only if the memory side of its access type can accept a new serial.
    always_comb begin
        rd_open  = !memAccessReadBusy  && !rd_valid[nextMemReadSerial];
        wr_open  = !memAccessWriteBusy && !wr_valid[nextMemWriteSerial];
        eligible = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = reqValid[i] && (reqWE[i] ? wr_open : rd_open);
        end
    end

    // First eligible port at or after rr_ptr, wrapping.
    always_comb begin
        logic [OWN_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
    end

    // Zero-latency issue onto the memory port.
    always_comb begin
        reqAck             = '0;
        reqSerial          = '0;
        memAccessAddr      = '0;
        memAccessWriteData = '0;
        memAccessRE        = 1'b0;
        memAccessWE        = 1'b0;
        grant_we           = reqWE[grant_idx];
        if (grant_any) begin
            reqAck[grant_idx]  = 1'b1;
            memAccessRE        = !grant_we;
            memAccessWE        = grant_we;
            memAccessAddr      = reqAddr[32'(grant_idx) * ADDR_W +: ADDR_W];
            memAccessWriteData = reqWData[32'(grant_idx) * DATA_W +: DATA_W];
            reqSerial          = grant_we ? nextMemWriteSerial : nextMemReadSerial;
        end
    end

    // Allocation and release events; both look at the table as it stood at the start of the cycle.
    always_comb begin
        rd_alloc      = grant_any && !grant_we;
        wr_alloc      = grant_any && grant_we;
        rd_free       = memReadDataReady  && rd_valid[memReadSerial];
        wr_free       = memWriteDoneValid && wr_valid[memWriteDoneSerial];
        rd_unexpected = memReadDataReady  && !rd_valid[memReadSerial];
        wr_unexpected = memWriteDoneValid && !wr_valid[memWriteDoneSerial];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid         <= '0;
            wr_valid         <= '0;
            rr_ptr           <= '0;
            rd_count         <= '0;
            rspValid         <= '0;
            rspData          <= '0;
            rspSerial        <= '0;
            wrDone           <= '0;
            errUnexpected    <= 1'b0;
        end else begin
            rspValid <= '0;
            wrDone   <= '0;

            if (rd_free) begin
                rspValid              <= NUM_PORTS'(1) << rd_owner[memReadSerial];
                rspData               <= memReadData;
                rspSerial             <= memReadSerial;
                rd_valid[memReadSerial] <= 1'b0;
            end
            if (wr_free) begin
                wrDone                       <= NUM_PORTS'(1) << wr_owner[memWriteDoneSerial];
                wr_valid[memWriteDoneSerial] <= 1'b0;
            end
            if (rd_unexpected || wr_unexpected) begin
                errUnexpected <= 1'b1;
            end

            // An allocated serial was invalid, a freed one valid, so they never collide.
            if (rd_alloc) begin
                rd_valid[nextMemReadSerial] <= 1'b1;
            end
            if (wr_alloc) begin
                wr_valid[nextMemWriteSerial] <= 1'b1;
            end
            if (grant_any) begin
                rr_ptr <= wrap_add(grant_idx, 1);
            end

            case ({rd_alloc, rd_free})
                2'b10:   rd_count <= rd_count + CNT_W'(1);
                2'b01:   rd_count <= rd_count - CNT_W'(1);
                default: rd_count <= rd_count;
            endcase
        end
    end

    // Owner fields need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (rd_alloc) begin
            rd_owner[nextMemReadSerial] <= grant_idx;
        end
        if (wr_alloc) begin
            wr_owner[nextMemWriteSerial] <= grant_idx;
        end
    end

    assign outstandingReads = rd_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a serial-table reference model.
module tb_mem_port_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned SW = 4;
    localparam int unsigned NS = 1 << SW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    reqValid;
    logic [N-1:0]    reqWE;
    logic [N*AW-1:0] reqAddr;
    logic [N*DW-1:0] reqWData;
    logic [N-1:0]    reqAck;
    logic [SW-1:0]   reqSerial;
    logic [AW-1:0]   memAccessAddr;
    logic [DW-1:0]   memAccessWriteData;
    logic            memAccessRE;
    logic            memAccessWE;
    logic            memAccessReadBusy;
    logic            memAccessWriteBusy;
    logic [SW-1:0]   nextMemReadSerial;
    logic [SW-1:0]   nextMemWriteSerial;
    logic            memReadDataReady;
    logic [DW-1:0]   memReadData;
    logic [SW-1:0]   memReadSerial;
    logic            memWriteDoneValid;
    logic [SW-1:0]   memWriteDoneSerial;
    logic [N-1:0]    rspValid;
    logic [DW-1:0]   rspData;
    logic [SW-1:0]   rspSerial;
    logic [N-1:0]    wrDone;
    logic [SW:0]     outstandingReads;
    logic            errUnexpected;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .SERIAL_W(SW)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWE(reqWE), .reqAddr(reqAddr), .reqWData(reqWData),
        .reqAck(reqAck), .reqSerial(reqSerial),
        .memAccessAddr(memAccessAddr), .memAccessWriteData(memAccessWriteData),
        .memAccessRE(memAccessRE), .memAccessWE(memAccessWE),
        .memAccessReadBusy(memAccessReadBusy), .memAccessWriteBusy(memAccessWriteBusy),
        .nextMemReadSerial(nextMemReadSerial), .nextMemWriteSerial(nextMemWriteSerial),
        .memReadDataReady(memReadDataReady), .memReadData(memReadData),
        .memReadSerial(memReadSerial), .memWriteDoneValid(memWriteDoneValid),
        .memWriteDoneSerial(memWriteDoneSerial),
        .rspValid(rspValid), .rspData(rspData), .rspSerial(rspSerial), .wrDone(wrDone),
        .outstandingReads(outstandingReads), .errUnexpected(errUnexpected)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        reqValid = '0; reqWE = '0; reqAddr = '0; reqWData = '0;
        memAccessReadBusy = 1'b0; memAccessWriteBusy = 1'b0;
        nextMemReadSerial = '0; nextMemWriteSerial = '0;
        memReadDataReady = 1'b0; memReadData = '0; memReadSerial = '0;
        memWriteDoneValid = 1'b0; memWriteDoneSerial = '0;
    endtask

    task automatic pulse_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        reqValid = 3'b111; reqWE = 3'b010;
        #1;
        total++; if (reqAck !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", reqAck); end
        total++; if (memAccessRE !== 1'b0 || memAccessWE !== 1'b0) begin bad++; $display("FAIL reset_strobes got RE=%b WE=%b exp 0/0", memAccessRE, memAccessWE); end
        tick();
        rst = 1'b0;
        idle_inputs();
        total++; if (rspValid !== 3'b000 || wrDone !== 3'b000) begin bad++; $display("FAIL reset_rsp got rspValid=%b wrDone=%b exp 000/000", rspValid, wrDone); end
        total++; if (rspData !== '0 || rspSerial !== '0) begin bad++; $display("FAIL reset_rspdata got data=%h serial=%0d exp 0/0", rspData, rspSerial); end
        total++; if (outstandingReads !== 5'd0 || errUnexpected !== 1'b0) begin bad++; $display("FAIL reset_count got out=%0d err=%b exp 0/0", outstandingReads, errUnexpected); end
    endtask

    task automatic test_single_read;
        pulse_reset();
        reqValid = 3'b010; reqWE = 3'b000;
        reqAddr[1*AW +: AW] = 32'h0000_1000;
        nextMemReadSerial = 4'd3;
        #1;
        total++; if (reqAck !== 3'b010) begin bad++; $display("FAIL single_ack got=%b exp=010", reqAck); end
        total++; if (memAccessRE !== 1'b1 || memAccessWE !== 1'b0) begin bad++; $display("FAIL single_strobe got RE=%b WE=%b exp 1/0", memAccessRE, memAccessWE); end
        total++; if (reqSerial !== 4'd3) begin bad++; $display("FAIL single_serial got=%0d exp=3", reqSerial); end
        total++; if (memAccessAddr !== 32'h0000_1000) begin bad++; $display("FAIL single_addr got=%h exp=00001000", memAccessAddr); end
        tick();
        idle_inputs();
        total++; if (outstandingReads !== 5'd1) begin bad++; $display("FAIL single_out1 got=%0d exp=1", outstandingReads); end
        memReadDataReady = 1'b1; memReadSerial = 4'd3; memReadData = 128'hAB;
        tick();
        idle_inputs();
        total++; if (rspValid !== 3'b010 || rspData !== 128'hAB || rspSerial !== 4'd3) begin bad++; $display("FAIL single_rsp got valid=%b data=%h serial=%0d exp 010/ab/3", rspValid, rspData, rspSerial); end
        total++; if (outstandingReads !== 5'd0) begin bad++; $display("FAIL single_out0 got=%0d exp=0", outstandingReads); end
        tick();
        total++; if (rspValid !== 3'b000) begin bad++; $display("FAIL single_rsp_pulse got=%b exp=000", rspValid); end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_ack;
        pulse_reset();
        reqValid = 3'b111; reqWE = 3'b000;
        for (int i = 0; i < 6; i++) begin
            nextMemReadSerial = SW'(i);
            #1;
            exp_ack = 3'b001 << (i % 3);
            total++; if (reqAck !== exp_ack) begin bad++; $display("FAIL rr_order cycle=%0d got=%b exp=%b", i, reqAck, exp_ack); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_busy_full;
        pulse_reset();
        reqValid = 3'b101; reqWE = 3'b100;
        memAccessReadBusy = 1'b1; nextMemWriteSerial = 4'd1;
        #1;
        total++; if (reqAck !== 3'b100 || memAccessWE !== 1'b1 || memAccessRE !== 1'b0) begin bad++; $display("FAIL busy_write got ack=%b RE=%b WE=%b exp 100/0/1", reqAck, memAccessRE, memAccessWE); end
        total++; if (reqSerial !== 4'd1) begin bad++; $display("FAIL busy_wserial got=%0d exp=1", reqSerial); end
        tick();
        idle_inputs();
        reqValid = 3'b001;
        for (int i = 0; i < NS; i++) begin
            nextMemReadSerial = SW'(i);
            #1;
            total++; if (reqAck !== 3'b001) begin bad++; $display("FAIL fill_ack serial=%0d got=%b exp=001", i, reqAck); end
            tick();
        end
        total++; if (outstandingReads !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", outstandingReads); end
        nextMemReadSerial = 4'd9;
        #1;
        total++; if (reqAck !== 3'b000 || memAccessRE !== 1'b0) begin bad++; $display("FAIL full_block got ack=%b RE=%b exp 000/0", reqAck, memAccessRE); end
        nextMemReadSerial = 4'd5;
        memReadDataReady = 1'b1; memReadSerial = 4'd5; memReadData = 128'h5;
        #1;
        total++; if (reqAck !== 3'b000) begin bad++; $display("FAIL free_same_cycle got=%b exp=000", reqAck); end
        tick();
        memReadDataReady = 1'b0;
        total++; if (outstandingReads !== 5'd15 || rspValid !== 3'b001) begin bad++; $display("FAIL free_count got out=%0d rsp=%b exp 15/001", outstandingReads, rspValid); end
        #1;
        total++; if (reqAck !== 3'b001 || reqSerial !== 4'd5) begin bad++; $display("FAIL refill_ack got ack=%b serial=%0d exp 001/5", reqAck, reqSerial); end
        tick();
        idle_inputs();
        total++; if (outstandingReads !== 5'd16) begin bad++; $display("FAIL refill_count got=%0d exp=16", outstandingReads); end
    endtask

    task automatic test_out_of_order;
        logic [N-1:0] rdy_port [3];
        logic [SW-1:0] rdy_ser [3];
        logic [N-1:0] exp_rsp [3];
        rdy_port = '{3'b001, 3'b100, 3'b010};
        rdy_ser  = '{4'd5, 4'd6, 4'd7};
        exp_rsp  = '{3'b010, 3'b001, 3'b100};
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            reqValid = rdy_port[i]; nextMemReadSerial = rdy_ser[i];
            #1;
            total++; if (reqAck !== rdy_port[i]) begin bad++; $display("FAIL ooo_issue idx=%0d got=%b exp=%b", i, reqAck, rdy_port[i]); end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            memReadDataReady = 1'b1;
            memReadSerial    = (i == 0) ? 4'd7 : (i == 1) ? 4'd5 : 4'd6;
            memReadData      = DW'(32'hC000 + i);
            tick();
            memReadDataReady = 1'b0;
            total++; if (rspValid !== exp_rsp[i] || rspData !== DW'(32'hC000 + i)) begin bad++; $display("FAIL ooo_ret idx=%0d got valid=%b data=%h exp %b/%h", i, rspValid, rspData, exp_rsp[i], 32'hC000 + i); end
        end
        total++; if (outstandingReads !== 5'd0 || errUnexpected !== 1'b0) begin bad++; $display("FAIL ooo_final got out=%0d err=%b exp 0/0", outstandingReads, errUnexpected); end
    endtask

    task automatic test_write_same_cycle;
        logic [DW-1:0] wd;
        wd = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEED_F00D};
        pulse_reset();
        reqValid = 3'b001; nextMemReadSerial = 4'd4;
        #1;
        total++; if (reqAck !== 3'b001) begin bad++; $display("FAIL wsc_read got=%b exp=001", reqAck); end
        tick();
        idle_inputs();
        reqValid = 3'b100; reqWE = 3'b100; nextMemWriteSerial = 4'd2;
        reqWData[2*DW +: DW] = wd;
        #1;
        total++; if (reqAck !== 3'b100 || reqSerial !== 4'd2 || memAccessWriteData !== wd) begin bad++; $display("FAIL wsc_write got ack=%b serial=%0d data=%h exp 100/2/%h", reqAck, reqSerial, memAccessWriteData, wd); end
        tick();
        idle_inputs();
        memWriteDoneValid = 1'b1; memWriteDoneSerial = 4'd2;
        memReadDataReady = 1'b1; memReadSerial = 4'd4; memReadData = 128'h55;
        reqValid = 3'b010; nextMemReadSerial = 4'd7;
        #1;
        total++; if (reqAck !== 3'b010) begin bad++; $display("FAIL wsc_grant_free got=%b exp=010", reqAck); end
        tick();
        idle_inputs();
        total++; if (wrDone !== 3'b100 || rspValid !== 3'b001 || rspData !== 128'h55) begin bad++; $display("FAIL wsc_both got wrDone=%b rsp=%b data=%h exp 100/001/55", wrDone, rspValid, rspData); end
        total++; if (outstandingReads !== 5'd1 || errUnexpected !== 1'b0) begin bad++; $display("FAIL wsc_count got out=%0d err=%b exp 1/0", outstandingReads, errUnexpected); end
    endtask

    task automatic test_reset_midflight;
        pulse_reset();
        reqValid = 3'b001; nextMemReadSerial = 4'd0;
        tick();
        reqValid = 3'b010; nextMemReadSerial = 4'd1;
        tick();
        idle_inputs();
        total++; if (outstandingReads !== 5'd2) begin bad++; $display("FAIL mid_pre got=%0d exp=2", outstandingReads); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        memReadDataReady = 1'b1; memReadSerial = 4'd0; memReadData = 128'h77;
        tick();
        idle_inputs();
        total++; if (rspValid !== 3'b000 || errUnexpected !== 1'b1 || outstandingReads !== 5'd0) begin bad++; $display("FAIL mid_late got rsp=%b err=%b out=%0d exp 000/1/0", rspValid, errUnexpected, outstandingReads); end
        tick();
        total++; if (errUnexpected !== 1'b1) begin bad++; $display("FAIL mid_sticky got=%b exp=1", errUnexpected); end
        pulse_reset();
        total++; if (errUnexpected !== 1'b0) begin bad++; $display("FAIL mid_clear got=%b exp=0", errUnexpected); end
    endtask

    // Reference: serial tables as plain arrays, round robin as a modular scan.
    task automatic test_random;
        bit m_rv [NS]; int m_ro [NS];
        bit m_wv [NS]; int m_wo [NS];
        int m_rr, m_cnt, eg, p, s;
        bit m_err, el;
        logic [N-1:0] exp_ack, exp_rsp, exp_wr;
        logic [DW-1:0] exp_data;
        pulse_reset();
        for (int i = 0; i < NS; i++) begin m_rv[i] = 0; m_wv[i] = 0; m_ro[i] = 0; m_wo[i] = 0; end
        m_rr = 0; m_cnt = 0; m_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reqValid = N'($urandom_range(0, 7));
            reqWE    = N'($urandom_range(0, 7));
            for (int q = 0; q < N; q++) begin
                reqAddr[q*AW +: AW]  = $urandom;
                reqWData[q*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
            memAccessReadBusy  = ($urandom_range(0, 3) == 0);
            memAccessWriteBusy = ($urandom_range(0, 3) == 0);
            nextMemReadSerial  = SW'($urandom_range(0, NS - 1));
            nextMemWriteSerial = SW'($urandom_range(0, NS - 1));
            memReadDataReady = 1'b0; memWriteDoneValid = 1'b0;
            s = $urandom_range(0, NS - 1);
            for (int k = 0; k < NS; k++) if (!memReadDataReady && m_rv[(s + k) % NS]) begin
                memReadDataReady = $urandom_range(0, 1); memReadSerial = SW'((s + k) % NS);
            end
            if (!memReadDataReady && $urandom_range(0, 40) == 0) begin
                memReadDataReady = 1'b1; memReadSerial = SW'($urandom_range(0, NS - 1));
            end
            memReadData = {$urandom, $urandom, $urandom, $urandom};
            s = $urandom_range(0, NS - 1);
            for (int k = 0; k < NS; k++) if (!memWriteDoneValid && m_wv[(s + k) % NS]) begin
                memWriteDoneValid = $urandom_range(0, 1); memWriteDoneSerial = SW'((s + k) % NS);
            end
            #1;
            eg = -1;
            for (int k = 0; k < N; k++) begin
                p  = (m_rr + k) % N;
                el = reqValid[p] && (reqWE[p] ? (!memAccessWriteBusy && !m_wv[nextMemWriteSerial])
                                              : (!memAccessReadBusy && !m_rv[nextMemReadSerial]));
                if (el && eg < 0) eg = p;
            end
            exp_ack = (eg >= 0) ? N'(1 << eg) : '0;
            total++; if (reqAck !== exp_ack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, reqAck, exp_ack); end
            if (eg >= 0) begin
                total++; if (memAccessRE !== !reqWE[eg] || memAccessWE !== reqWE[eg] || memAccessAddr !== reqAddr[eg*AW +: AW]
                             || reqSerial !== (reqWE[eg] ? nextMemWriteSerial : nextMemReadSerial)) begin
                    bad++; $display("FAIL rnd_issue cyc=%0d got RE=%b WE=%b addr=%h serial=%0d port=%0d", cyc, memAccessRE, memAccessWE, memAccessAddr, reqSerial, eg);
                end
                if (reqWE[eg]) begin
                    total++; if (memAccessWriteData !== reqWData[eg*DW +: DW]) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, memAccessWriteData, reqWData[eg*DW +: DW]); end
                end
            end else begin
                total++; if (memAccessRE !== 1'b0 || memAccessWE !== 1'b0) begin bad++; $display("FAIL rnd_idle cyc=%0d got RE=%b WE=%b exp 0/0", cyc, memAccessRE, memAccessWE); end
            end
            exp_rsp = '0; exp_wr = '0; exp_data = memReadData;
            if (memReadDataReady) begin
                if (m_rv[memReadSerial]) begin exp_rsp = N'(1 << m_ro[memReadSerial]); m_rv[memReadSerial] = 0; m_cnt--; end
                else m_err = 1;
            end
            if (memWriteDoneValid) begin
                if (m_wv[memWriteDoneSerial]) begin exp_wr = N'(1 << m_wo[memWriteDoneSerial]); m_wv[memWriteDoneSerial] = 0; end
                else m_err = 1;
            end
            if (eg >= 0) begin
                if (reqWE[eg]) begin m_wv[nextMemWriteSerial] = 1; m_wo[nextMemWriteSerial] = eg; end
                else begin m_rv[nextMemReadSerial] = 1; m_ro[nextMemReadSerial] = eg; m_cnt++; end
                m_rr = (eg + 1) % N;
            end
            tick();
            total++; if (rspValid !== exp_rsp || wrDone !== exp_wr) begin bad++; $display("FAIL rnd_route cyc=%0d got rsp=%b wr=%b exp %b/%b", cyc, rspValid, wrDone, exp_rsp, exp_wr); end
            if (exp_rsp != '0) begin
                total++; if (rspData !== exp_data) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rspData, exp_data); end
            end
            total++; if (outstandingReads !== (SW+1)'(m_cnt) || errUnexpected !== m_err) begin bad++; $display("FAIL rnd_state cyc=%0d got out=%0d err=%b exp %0d/%b", cyc, outstandingReads, errUnexpected, m_cnt, m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_busy_full();
        test_out_of_order();
        test_write_same_cycle();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
